// File: rtl/cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// cache_miss_ctrl: tag/valid/dirty/age controller for a 2-way set-assoc cache.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.  Rev 1.0
// ============================================================================
module cache_miss_ctrl #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [IDX_W-1:0]       i_req_index,
  input  logic [TAG_W-1:0]       i_req_tag,
  input  logic                   i_req_write,
  output logic                   o_resp_valid,
  output logic                   o_resp_hit,
  output logic                   o_resp_way,
  output logic                   o_mem_req_valid,
  input  logic                   i_mem_req_ready,
  output logic                   o_mem_req_we,
  output logic [TAG_W+IDX_W-1:0] o_mem_req_addr,
  input  logic                   i_mem_resp_valid,
  output logic                   o_fill_en,
  output logic                   o_fill_way,
  output logic [15:0]            o_stat_hits,
  output logic [15:0]            o_stat_misses
);

  localparam int SETS = 1 << IDX_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_WB_REQ  = 3'd2;
  localparam logic [2:0] S_WB_WAIT = 3'd3;
  localparam logic [2:0] S_RF_REQ  = 3'd4;
  localparam logic [2:0] S_RF_WAIT = 3'd5;
  localparam logic [2:0] S_RESP    = 3'd6;

  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_write;
  logic             r_way;
  logic             r_hit;

  logic [SETS-1:0]  r_valid0, r_valid1, r_dirty0, r_dirty1, r_age0, r_age1;
  logic [TAG_W-1:0] r_tags0 [SETS];
  logic [TAG_W-1:0] r_tags1 [SETS];

  logic             w_v0, w_v1, w_d0, w_d1, w_a0, w_a1;
  logic             w_hit0, w_hit1, w_hit, w_hit_way;
  logic             w_victim, w_victim_dirty;
  logic [TAG_W-1:0] w_victim_tag;
  logic             w_lookup_hit, w_fill, w_touch, w_touch_way;

  assign w_v0 = r_valid0[r_idx];
  assign w_v1 = r_valid1[r_idx];
  assign w_d0 = r_dirty0[r_idx];
  assign w_d1 = r_dirty1[r_idx];
  assign w_a0 = r_age0[r_idx];
  assign w_a1 = r_age1[r_idx];

  assign w_hit0    = w_v0 && (r_tags0[r_idx] == r_tag);
  assign w_hit1    = w_v1 && (r_tags1[r_idx] == r_tag);
  assign w_hit     = w_hit0 || w_hit1;
  assign w_hit_way = !w_hit0;

  // Invalid ways first; with both valid the older (age=1) way goes, ties to way 0.
  assign w_victim       = !w_v0 ? 1'b0 : (!w_v1 ? 1'b1 : (w_a1 && !w_a0));
  assign w_victim_dirty = w_victim ? (w_v1 && w_d1) : (w_v0 && w_d0);
  assign w_victim_tag   = r_way ? r_tags1[r_idx] : r_tags0[r_idx];

  assign w_lookup_hit = (r_state == S_LOOKUP) && w_hit;
  assign w_fill       = (r_state == S_RF_WAIT) && i_mem_resp_valid;
  assign w_touch      = w_lookup_hit || w_fill;
  assign w_touch_way  = w_fill ? r_way : w_hit_way;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_tag   <= '0;
      r_write <= 1'b0;
      r_way   <= 1'b0;
      r_hit   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_req_valid) begin
          r_idx   <= i_req_index;
          r_tag   <= i_req_tag;
          r_write <= i_req_write;
          r_state <= S_LOOKUP;
        end
        S_LOOKUP: begin
          r_hit <= w_hit;
          if (w_hit) begin
            r_way   <= w_hit_way;
            r_state <= S_RESP;
          end else begin
            r_way   <= w_victim;
            r_state <= w_victim_dirty ? S_WB_REQ : S_RF_REQ;
          end
        end
        S_WB_REQ:  if (i_mem_req_ready)  r_state <= S_WB_WAIT;
        S_WB_WAIT: if (i_mem_resp_valid) r_state <= S_RF_REQ;
        S_RF_REQ:  if (i_mem_req_ready)  r_state <= S_RF_WAIT;
        S_RF_WAIT: if (i_mem_resp_valid) r_state <= S_RESP;
        S_RESP:    r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid0 <= '0;
      r_valid1 <= '0;
      r_dirty0 <= '0;
      r_dirty1 <= '0;
      r_age0   <= '0;
      r_age1   <= '0;
    end else begin
      if (w_lookup_hit && r_write) begin
        if (w_hit_way) r_dirty1[r_idx] <= 1'b1;
        else           r_dirty0[r_idx] <= 1'b1;
      end
      if (w_fill) begin
        if (r_way) begin
          r_valid1[r_idx] <= 1'b1;
          r_dirty1[r_idx] <= r_write;
        end else begin
          r_valid0[r_idx] <= 1'b1;
          r_dirty0[r_idx] <= r_write;
        end
      end
      // The other way only ages if it holds a line.
      if (w_touch) begin
        if (w_touch_way) begin
          r_age1[r_idx] <= 1'b0;
          if (w_v0) r_age0[r_idx] <= 1'b1;
        end else begin
          r_age0[r_idx] <= 1'b0;
          if (w_v1) r_age1[r_idx] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      if (r_way) r_tags1[r_idx] <= r_tag;
      else       r_tags0[r_idx] <= r_tag;
    end
  end

  assign o_req_ready     = (r_state == S_IDLE);
  assign o_resp_valid    = (r_state == S_RESP);
  assign o_resp_hit      = (r_state == S_RESP) && r_hit;
  assign o_resp_way      = (r_state == S_RESP) && r_way;
  assign o_mem_req_valid = (r_state == S_WB_REQ) || (r_state == S_RF_REQ);
  assign o_mem_req_we    = (r_state == S_WB_REQ);
  assign o_fill_en       = w_fill;
  assign o_fill_way      = r_way;

  always_comb begin
    o_mem_req_addr = '0;
    if (r_state == S_WB_REQ)      o_mem_req_addr = {w_victim_tag, r_idx};
    else if (r_state == S_RF_REQ) o_mem_req_addr = {r_tag, r_idx};
  end

`ifdef CACHE_STATS_EN
  logic [15:0] r_stat_hits, r_stat_misses;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_hits   <= 16'd0;
      r_stat_misses <= 16'd0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit) begin
        if (r_stat_hits != 16'hFFFF) r_stat_hits <= r_stat_hits + 16'd1;
      end else begin
        if (r_stat_misses != 16'hFFFF) r_stat_misses <= r_stat_misses + 16'd1;
      end
    end
  end

  assign o_stat_hits   = r_stat_hits;
  assign o_stat_misses = r_stat_misses;
`else
  assign o_stat_hits   = 16'd0;
  assign o_stat_misses = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cache_miss_ctrl: directed bench with a set/way reference model and a
// per-cycle output checker.  Rev 1.0
// ============================================================================
module tb_cache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_write, i_mem_req_ready, i_mem_resp_valid;
  logic [3:0]  i_req_index;
  logic [7:0]  i_req_tag;
  logic        o_req_ready, o_resp_valid, o_resp_hit, o_resp_way;
  logic        o_mem_req_valid, o_mem_req_we, o_fill_en, o_fill_way;
  logic [11:0] o_mem_req_addr;
  logic [15:0] o_stat_hits, o_stat_misses;

  always #5 clk = ~clk;

  cache_miss_ctrl #(.IDX_W(4), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_index(i_req_index), .i_req_tag(i_req_tag), .i_req_write(i_req_write),
    .o_resp_valid(o_resp_valid), .o_resp_hit(o_resp_hit), .o_resp_way(o_resp_way),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_we(o_mem_req_we), .o_mem_req_addr(o_mem_req_addr),
    .i_mem_resp_valid(i_mem_resp_valid),
    .o_fill_en(o_fill_en), .o_fill_way(o_fill_way),
    .o_stat_hits(o_stat_hits), .o_stat_misses(o_stat_misses)
  );

  typedef struct packed {
    logic        hit;
    logic        way;
    logic        wb;
    logic [11:0] wb_addr;
    logic [11:0] rf_addr;
  } txn_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: per set, per way ----------------
  logic       m_valid [16][2];
  logic       m_dirty [16][2];
  logic       m_age   [16][2];
  logic [7:0] m_tag   [16][2];
  logic [15:0] m_hits, m_misses;

  task automatic model_reset();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0; m_age[s][w] = 1'b0; m_tag[s][w] = 8'h00;
      end
    m_hits = 16'd0; m_misses = 16'd0;
  endtask

  task automatic touch(input int s, input int w);
    m_age[s][w] = 1'b0;
    if (m_valid[s][1-w]) m_age[s][1-w] = 1'b1;
  endtask

  task automatic predict(input logic [3:0] idx, input logic [7:0] tag, input logic wr, output txn_t p);
    int s, v;
    s = int'(idx);
    p = '0;
    if (m_valid[s][0] && m_tag[s][0] == tag)      begin p.hit = 1'b1; p.way = 1'b0; end
    else if (m_valid[s][1] && m_tag[s][1] == tag) begin p.hit = 1'b1; p.way = 1'b1; end
    if (p.hit) begin
      if (m_hits != 16'hFFFF) m_hits++;
      if (wr) m_dirty[s][p.way] = 1'b1;
      touch(s, int'(p.way));
    end else begin
      if (m_misses != 16'hFFFF) m_misses++;
      if (!m_valid[s][0])                v = 0;
      else if (!m_valid[s][1])           v = 1;
      else if (m_age[s][0] == m_age[s][1]) v = 0;
      else                               v = m_age[s][1] ? 1 : 0;
      p.way     = v[0];
      p.wb      = m_valid[s][v] && m_dirty[s][v];
      p.wb_addr = {m_tag[s][v], idx};
      p.rf_addr = {tag, idx};
      m_tag[s][v] = tag; m_valid[s][v] = 1'b1; m_dirty[s][v] = wr;
      touch(s, v);
    end
  endtask

  function automatic logic [15:0] exp_hits();
`ifdef CACHE_STATS_EN
    return m_hits;
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [15:0] exp_misses();
`ifdef CACHE_STATS_EN
    return m_misses;
`else
    return 16'd0;
`endif
  endfunction

  // ---------------- memory responder ----------------
  int   ready_delay = 0;
  logic stray_req = 1'b0;
  logic rf_wait_flag = 1'b0;

  initial begin
    int pend, wcnt;
    logic hs_prev, hs_prev_we;
    pend = 0; wcnt = 0; hs_prev = 1'b0; hs_prev_we = 1'b0;
    i_mem_req_ready = 1'b0; i_mem_resp_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        pend = 0; wcnt = 0; hs_prev = 1'b0; rf_wait_flag = 1'b0;
        i_mem_req_ready = 1'b0; i_mem_resp_valid = 1'b0;
      end else begin
        rf_wait_flag = hs_prev && !hs_prev_we;
        if (hs_prev) pend = 2;
        i_mem_resp_valid = 1'b0;
        if (pend > 0) begin pend--; if (pend == 0) i_mem_resp_valid = 1'b1; end
        if (stray_req) i_mem_resp_valid = 1'b1;
        if (o_mem_req_valid) begin
          if (wcnt >= ready_delay) i_mem_req_ready = 1'b1;
          else begin i_mem_req_ready = 1'b0; wcnt++; end
        end else begin
          i_mem_req_ready = 1'b0; wcnt = 0;
        end
        hs_prev    = o_mem_req_valid && i_mem_req_ready;
        hs_prev_we = o_mem_req_we;
      end
    end
  end

  // ---------------- per-cycle compare process ----------------
  txn_t txq[$];
  int   acc_cnt = 0;
  logic busy = 1'b0;
  logic        obs_hit, obs_way;
  logic [11:0] obs_wb_addr, obs_rf_addr;

  initial begin
    txn_t cur;
    int seen_acc, acc_cyc, exp_resp_cyc, hs, nr, nreq;
    logic prev_wait, wb_phase, exp_fill, exp_rv;
    cur = '0; seen_acc = 0; acc_cyc = 0; exp_resp_cyc = -1; hs = 0; nr = 0; prev_wait = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_req_ready", 32'(o_req_ready), 32'd1);
        check("rst_mem_req_valid", 32'(o_mem_req_valid), 32'd0);
        check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
        check("rst_fill_en", 32'(o_fill_en), 32'd0);
        check("rst_stat_hits", 32'(o_stat_hits), 32'd0);
        check("rst_stat_misses", 32'(o_stat_misses), 32'd0);
        busy = 1'b0; prev_wait = 1'b0; exp_resp_cyc = -1; seen_acc = acc_cnt;
      end else begin
        if (acc_cnt != seen_acc) begin
          seen_acc = acc_cnt;
          if (txq.size() > 0) cur = txq.pop_front();
          busy = 1'b1; acc_cyc = cyc; hs = 0; nr = 0;
          exp_resp_cyc = cur.hit ? cyc + 1 : -1;
        end
        nreq = cur.wb ? 2 : 1;
        check("req_ready", 32'(o_req_ready), 32'(!busy));
        if (o_mem_req_valid) begin
          if (!busy || cur.hit || cyc == acc_cyc || hs >= nreq || (cur.wb && hs == 1 && nr == 0))
            check("unexpected_mem_req", 32'd1, 32'd0);
          else begin
            wb_phase = cur.wb && hs == 0;
            check("mem_req_we", 32'(o_mem_req_we), 32'(wb_phase));
            check("mem_req_addr", 32'(o_mem_req_addr), 32'(wb_phase ? cur.wb_addr : cur.rf_addr));
            if (i_mem_req_ready) begin
              hs++;
              if (wb_phase) obs_wb_addr = o_mem_req_addr;
              else          obs_rf_addr = o_mem_req_addr;
            end
          end
        end else if (prev_wait) check("mem_req_dropped", 32'd0, 32'd1);
        prev_wait = o_mem_req_valid && !i_mem_req_ready;

        exp_fill = busy && !cur.hit && i_mem_resp_valid && hs == nreq && nr == nreq - 1;
        check("fill_en", 32'(o_fill_en), 32'(exp_fill));
        if (busy && i_mem_resp_valid && hs > nr) nr++;
        if (exp_fill) exp_resp_cyc = cyc + 1;
        if (busy && !cur.hit && cyc > acc_cyc) check("fill_way", 32'(o_fill_way), 32'(cur.way));

        exp_rv = busy && cyc == exp_resp_cyc;
        check("resp_valid", 32'(o_resp_valid), 32'(exp_rv));
        if (exp_rv) begin
          check("resp_hit", 32'(o_resp_hit), 32'(cur.hit));
          check("resp_way", 32'(o_resp_way), 32'(cur.way));
          obs_hit = o_resp_hit; obs_way = o_resp_way;
          busy = 1'b0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue_req(input logic [3:0] idx, input logic [7:0] tag, input logic wr, input int rdly);
    txn_t p;
    int k;
    ready_delay = rdly;
    k = 0;
    do begin @(posedge clk); #1; k++; end while ((busy || !o_req_ready) && k < 400);
    if (k >= 400) check("idle_timeout", 32'd1, 32'd0);
    predict(idx, tag, wr, p);
    txq.push_back(p);
    i_req_valid = 1'b1; i_req_index = idx; i_req_tag = tag; i_req_write = wr;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    acc_cnt++;
  endtask

  task automatic do_req(input logic [3:0] idx, input logic [7:0] tag, input logic wr, input int rdly);
    int k;
    issue_req(idx, tag, wr, rdly);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (busy && k < 400);
    if (k >= 400) check("resp_timeout", 32'd1, 32'd0);
    check("stat_hits", 32'(o_stat_hits), 32'(exp_hits()));
    check("stat_misses", 32'(o_stat_misses), 32'(exp_misses()));
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    txq.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; i_req_valid = 1'b0; i_req_write = 1'b0;
    i_req_index = 4'h0; i_req_tag = 8'h00;
    obs_hit = 1'b0; obs_way = 1'b0; obs_wb_addr = '0; obs_rf_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("lit_reset_ready", 32'(o_req_ready), 32'd1);
    check("lit_reset_memvalid", 32'(o_mem_req_valid), 32'd0);

    // Cold miss then hit on set 3
    do_req(4'd3, 8'h11, 1'b0, 0);
    check("lit_first_rf_addr", 32'(obs_rf_addr), 32'h113);
    check("lit_first_hit", 32'(obs_hit), 32'd0);
    check("lit_first_way", 32'(obs_way), 32'd0);
    do_req(4'd3, 8'h11, 1'b0, 0);
    check("lit_rehit", 32'(obs_hit), 32'd1);
    check("lit_rehit_way", 32'(obs_way), 32'd0);

    // Second way, re-touch way 0, then age-based victim
    do_req(4'd3, 8'h22, 1'b0, 1);
    check("lit_way1_fill", 32'(obs_way), 32'd1);
    do_req(4'd3, 8'h11, 1'b0, 0);
    do_req(4'd3, 8'h33, 1'b0, 0);
    check("lit_victim_way", 32'(obs_way), 32'd1);
    check("lit_victim_addr", 32'(obs_rf_addr), 32'h333);

    // Dirty eviction with ready held low
    do_req(4'd5, 8'h44, 1'b1, 0);
    do_req(4'd5, 8'h55, 1'b0, 0);
    do_req(4'd5, 8'h66, 1'b0, 5);
    check("lit_wb_addr", 32'(obs_wb_addr), 32'h445);
    check("lit_rf_after_wb", 32'(obs_rf_addr), 32'h665);

    // Write hit marks line dirty; it is written back when evicted later
    do_req(4'd3, 8'h11, 1'b1, 0);
    do_req(4'd3, 8'h77, 1'b0, 2);
    do_req(4'd3, 8'h88, 1'b0, 0);
    check("lit_wb_after_write_hit", 32'(obs_wb_addr), 32'h113);

    // Stray memory response while idle is ignored
    @(negedge clk); stray_req = 1'b1;
    @(negedge clk); stray_req = 1'b0;
    repeat (2) @(posedge clk);
    do_req(4'd3, 8'h77, 1'b0, 0);
    check("lit_hit_after_stray", 32'(obs_hit), 32'd1);

    // Reset during refill wait abandons the transaction
    issue_req(4'd7, 8'h99, 1'b0, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (!rf_wait_flag && k < 400);
    if (k >= 400) check("rf_wait_timeout", 32'd1, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("lit_async_memvalid", 32'(o_mem_req_valid), 32'd0);
    check("lit_async_ready", 32'(o_req_ready), 32'd1);
    check("lit_async_resp", 32'(o_resp_valid), 32'd0);
    model_reset();
    txq.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    do_req(4'd7, 8'h99, 1'b0, 0);
    check("lit_miss_after_reset", 32'(obs_hit), 32'd0);

    // Statistics from a clean reset: 2 misses, 3 hits
    pulse_reset();
    do_req(4'd2, 8'hA1, 1'b0, 0);
    do_req(4'd2, 8'hA1, 1'b0, 0);
    do_req(4'd2, 8'hA1, 1'b1, 0);
    do_req(4'd2, 8'hB2, 1'b0, 0);
    do_req(4'd2, 8'hB2, 1'b0, 0);
`ifdef CACHE_STATS_EN
    check("lit_stat_hits", 32'(o_stat_hits), 32'd3);
    check("lit_stat_misses", 32'(o_stat_misses), 32'd2);
`else
    check("lit_stat_hits", 32'(o_stat_hits), 32'd0);
    check("lit_stat_misses", 32'(o_stat_misses), 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
